// File: rtl/round_referee_pkg.sv
// Shared definitions for the round referee and the player stages it drives:
// FSM encoding, life count, winner codes and player-word field layout.
package round_referee_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ROUND_RST = 3'd1,
        ST_PLAY      = 3'd2,
        ST_KO_HOLD   = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int unsigned LIVES_W = 2;
    typedef logic [LIVES_W-1:0] lives_t;
    localparam lives_t LIVES_MAX = 2'd3;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    // Player word layout: [3:2] place, [1:0] health
    localparam int unsigned PLAYER_W   = 4;
    localparam int unsigned HEALTH_LSB = 0;
    localparam int unsigned HEALTH_MSB = 1;
    localparam int unsigned PLACE_LSB  = 2;
    localparam int unsigned PLACE_MSB  = 3;

    typedef struct packed {
        logic [PLACE_MSB-PLACE_LSB:0]   place;
        logic [HEALTH_MSB-HEALTH_LSB:0] health;
    } player_t;

    localparam int unsigned RST_CYC = 2;

    function automatic lives_t lives_dec(input lives_t l);
        return (l == '0) ? '0 : l - 2'd1;
    endfunction

    function automatic winner_t judge(input lives_t l1, input lives_t l2);
        if (l1 == '0 && l2 == '0) return WIN_DRAW;
        if (l2 == '0)             return WIN_P1;
        if (l1 == '0)             return WIN_P2;
        return WIN_NONE;
    endfunction

endpackage

// File: rtl/round_referee_tick_gen.sv
// Move-strobe prescaler: counts 0..TICK_DIV-1 and wraps. tick flags that the
// count reaches its terminal value on the next cycle, so the parent can
// register its strobe and still have it line up with the terminal count.
module tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == CNT_W'(TICK_DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = !clear && (count == CNT_W'(TICK_DIV - 2));

endmodule

// File: rtl/round_referee.sv
// Match referee: sequences round resets, paces player moves with a strobe,
// detects knockouts, tracks lives and declares the winner.
module round_referee
    import round_referee_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned KO_HOLD  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PLAYER_W-1:0] p1_state,
    input  logic [PLAYER_W-1:0] p2_state,
    output logic                control,
    output logic                round_reset_n,
    output logic [LIVES_W-1:0]  lives1,
    output logic [LIVES_W-1:0]  lives2,
    output logic                game_over,
    output logic [1:0]          winner
);
    localparam int unsigned HOLD_CYC = KO_HOLD * TICK_DIV;
    localparam int unsigned HOLD_W   = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

    state_t              state, state_n;
    logic                rst_cnt, rst_cnt_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    lives_t              lives1_n, lives2_n;
    winner_t             winner_n;
    logic                control_n;
    logic                clear_c;
    logic                tick_c;
    logic                ko1_c, ko2_c;
    player_t             p1_c, p2_c;
    logic                unused_place_c;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (clear_c),
        .tick  (tick_c)
    );

    assign p1_c  = player_t'(p1_state);
    assign p2_c  = player_t'(p2_state);
    assign ko1_c = (p1_c.health == '0);
    assign ko2_c = (p2_c.health == '0);
    assign unused_place_c = ^{p1_c.place, p2_c.place};

    // Next-state, next-lives and next-output decode
    always_comb begin
        state_n    = state;
        rst_cnt_n  = rst_cnt;
        hold_cnt_n = hold_cnt;
        lives1_n   = lives1;
        lives2_n   = lives2;
        winner_n   = winner_t'(winner);
        clear_c    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    lives1_n  = LIVES_MAX;
                    lives2_n  = LIVES_MAX;
                    rst_cnt_n = 1'b0;
                    state_n   = ST_ROUND_RST;
                end
            end
            ST_ROUND_RST: begin
                if (rst_cnt == 1'(RST_CYC - 1)) begin
                    clear_c = 1'b1;
                    state_n = ST_PLAY;
                end else begin
                    rst_cnt_n = rst_cnt + 1'b1;
                end
            end
            ST_PLAY: begin
                if (ko1_c || ko2_c) begin
                    if (ko1_c) lives1_n = lives_dec(lives1);
                    if (ko2_c) lives2_n = lives_dec(lives2);
                    hold_cnt_n = '0;
                    state_n    = ST_KO_HOLD;
                end
            end
            ST_KO_HOLD: begin
                if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
                    rst_cnt_n = 1'b0;
                    winner_n  = judge(lives1, lives2);
                    state_n   = (lives1 == '0 || lives2 == '0) ? ST_GAME_OVER : ST_ROUND_RST;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            ST_GAME_OVER: begin
                if (start) begin
                    lives1_n  = LIVES_MAX;
                    lives2_n  = LIVES_MAX;
                    winner_n  = WIN_NONE;
                    rst_cnt_n = 1'b0;
                    state_n   = ST_ROUND_RST;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // A knockout moves us out of PLAY, which also suppresses the strobe
        control_n = (state_n == ST_PLAY) && tick_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            rst_cnt       <= 1'b0;
            hold_cnt      <= '0;
            lives1        <= LIVES_MAX;
            lives2        <= LIVES_MAX;
            control       <= 1'b0;
            round_reset_n <= 1'b0;
            game_over     <= 1'b0;
            winner        <= WIN_NONE;
        end else begin
            state         <= state_n;
            rst_cnt       <= rst_cnt_n;
            hold_cnt      <= hold_cnt_n;
            lives1        <= lives1_n;
            lives2        <= lives2_n;
            control       <= control_n;
            round_reset_n <= (state_n == ST_PLAY) || (state_n == ST_KO_HOLD);
            game_over     <= (state_n == ST_GAME_OVER);
            winner        <= 2'(winner_n);
        end
    end

endmodule

// File: tb/tb_round_referee.sv
// Directed bench for round_referee with TICK_DIV=4, KO_HOLD=2.
module tb_round_referee;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] p1_state;
    logic [3:0] p2_state;
    logic       control;
    logic       round_reset_n;
    logic [1:0] lives1;
    logic [1:0] lives2;
    logic       game_over;
    logic [1:0] winner;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [3:0] HL = 4'b0111;

    round_referee #(.TICK_DIV(4), .KO_HOLD(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .p1_state      (p1_state),
        .p2_state      (p2_state),
        .control       (control),
        .round_reset_n (round_reset_n),
        .lives1        (lives1),
        .lives2        (lives2),
        .game_over     (game_over),
        .winner        (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       st;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [8:0] exp;
        int         reps;
    } vec_t;

    function automatic logic [8:0] pack_exp(input logic c, input logic rr,
                                            input logic [1:0] l1, input logic [1:0] l2,
                                            input logic g, input logic [1:0] w);
        return {c, rr, l1, l2, g, w};
    endfunction

    function automatic vec_t row(input string n, input logic r, input logic s,
                                 input logic [3:0] a, input logic [3:0] b,
                                 input logic c, input logic rr,
                                 input logic [1:0] l1, input logic [1:0] l2,
                                 input logic g, input logic [1:0] w, input int reps);
        vec_t v;
        v.name = n; v.rst = r; v.st = s; v.p1 = a; v.p2 = b;
        v.exp  = pack_exp(c, rr, l1, l2, g, w);
        v.reps = reps;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = {control, round_reset_n, lives1, lives2, game_over, winner};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got ctl/rrn/l1/l2/go/win=%b required %b", name, $time, got, exp);
        end
    endtask

    vec_t tbl[25];

    initial begin
        reset = 1'b1; start = 1'b0; p1_state = HL; p2_state = HL;

        //            name        rst st  p1  p2       ctl rrn l1 l2 go win   reps
        tbl[0]  = row("reset",    1, 0, HL, HL,      0, 0, 3, 3, 0, 2'b00, 1);
        tbl[1]  = row("idle",     0, 0, HL, HL,      0, 0, 3, 3, 0, 2'b00, 2);
        tbl[2]  = row("start",    0, 1, HL, HL,      0, 0, 3, 3, 0, 2'b00, 1);
        tbl[3]  = row("rrst",     0, 0, HL, HL,      0, 0, 3, 3, 0, 2'b00, 1);
        tbl[4]  = row("play_pre", 0, 0, HL, HL,      0, 1, 3, 3, 0, 2'b00, 3);
        tbl[5]  = row("strobe",   0, 0, HL, HL,      1, 1, 3, 3, 0, 2'b00, 1);
        tbl[6]  = row("play_pre", 0, 0, HL, HL,      0, 1, 3, 3, 0, 2'b00, 3);
        tbl[7]  = row("strobe",   0, 0, HL, HL,      1, 1, 3, 3, 0, 2'b00, 1);
        tbl[8]  = row("ko_p2",    0, 0, HL, 4'b1000, 0, 1, 3, 2, 0, 2'b00, 1);
        tbl[9]  = row("hold",     0, 1, HL, HL,      0, 1, 3, 2, 0, 2'b00, 7);
        tbl[10] = row("rrst2",    0, 1, HL, HL,      0, 0, 3, 2, 0, 2'b00, 2);
        tbl[11] = row("play_pre", 0, 0, HL, HL,      0, 1, 3, 2, 0, 2'b00, 3);
        tbl[12] = row("strobe",   0, 0, HL, HL,      1, 1, 3, 2, 0, 2'b00, 1);
        tbl[13] = row("play_pre", 0, 0, HL, HL,      0, 1, 3, 2, 0, 2'b00, 3);
        tbl[14] = row("ko_tc",    0, 0, HL, 4'b1000, 0, 1, 3, 1, 0, 2'b00, 1);
        tbl[15] = row("hold",     0, 0, HL, HL,      0, 1, 3, 1, 0, 2'b00, 7);
        tbl[16] = row("rrst3",    0, 0, HL, HL,      0, 0, 3, 1, 0, 2'b00, 2);
        tbl[17] = row("play",     0, 0, HL, HL,      0, 1, 3, 1, 0, 2'b00, 1);
        tbl[18] = row("ko_last",  0, 0, HL, 4'b1000, 0, 1, 3, 0, 0, 2'b00, 1);
        tbl[19] = row("hold",     0, 0, HL, HL,      0, 1, 3, 0, 0, 2'b00, 7);
        tbl[20] = row("over_p1",  0, 0, HL, HL,      0, 0, 3, 0, 1, 2'b01, 2);
        tbl[21] = row("restart",  0, 1, HL, HL,      0, 0, 3, 3, 0, 2'b00, 1);
        tbl[22] = row("rrst4",    0, 1, HL, HL,      0, 0, 3, 3, 0, 2'b00, 1);
        tbl[23] = row("play_st",  0, 1, HL, HL,      0, 1, 3, 3, 0, 2'b00, 3);
        tbl[24] = row("strobe",   0, 0, HL, HL,      1, 1, 3, 3, 0, 2'b00, 1);

        for (int i = 0; i < 25; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                reset = tbl[i].rst; start = tbl[i].st;
                p1_state = tbl[i].p1; p2_state = tbl[i].p2;
                step();
                check($sformatf("%s[%0d.%0d]", tbl[i].name, i, r), tbl[i].exp);
            end
        end
        start = 1'b0;

        // Simultaneous knockouts walk both lives down together to a draw
        for (int k = 0; k < 3; k++) begin
            logic [1:0] l;
            l = 2'(2 - k);
            p1_state = 4'b0100; p2_state = 4'b1100;
            step();
            check($sformatf("sim_ko%0d", k), pack_exp(0, 1, l, l, 0, 2'b00));
            p1_state = HL; p2_state = HL;
            repeat (7) step();
            check($sformatf("sim_hold%0d", k), pack_exp(0, 1, l, l, 0, 2'b00));
            step();
            if (k < 2) begin
                check($sformatf("sim_rrst%0d", k), pack_exp(0, 0, l, l, 0, 2'b00));
                step(); step();
                check($sformatf("sim_play%0d", k), pack_exp(0, 1, l, l, 0, 2'b00));
            end else begin
                check("draw", pack_exp(0, 0, 2'd0, 2'd0, 1, 2'b11));
            end
        end

        // Restart, knock out, then reset in the middle of the hold
        start = 1'b1;
        step();
        check("restart2", pack_exp(0, 0, 3, 3, 0, 2'b00));
        start = 1'b0;
        step(); step();
        check("play5", pack_exp(0, 1, 3, 3, 0, 2'b00));
        p2_state = 4'b1000;
        step();
        check("ko_p2b", pack_exp(0, 1, 3, 2, 0, 2'b00));
        p2_state = HL;
        step(); step();
        reset = 1'b1;
        step();
        check("reset_in_hold", pack_exp(0, 0, 3, 3, 0, 2'b00));
        reset = 1'b0;
        step(); step();
        check("idle_after_reset", pack_exp(0, 0, 3, 3, 0, 2'b00));
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        check("play_after_reset", pack_exp(0, 1, 3, 3, 0, 2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
